// File: rtl/lorenz_plotter_if.sv
// Solver-sample and framebuffer-write signals between the Lorenz solver,
// the plotter and the pixel memory.
interface lorenz_plotter_if;
  logic signed [26:0] x_in;
  logic signed [26:0] y_in;
  logic signed [26:0] z_in;
  logic               sample_valid;
  logic               step_en;
  logic        [18:0] pix_addr;
  logic        [7:0]  pix_data;
  logic               pix_we;
  logic               pix_ready;

  // master: the plotter (drives step_en and the write request)
  modport master (
    input  x_in, y_in, z_in, sample_valid, pix_ready,
    output step_en, pix_addr, pix_data, pix_we
  );

  // slave: solver and framebuffer side
  modport slave (
    output x_in, y_in, z_in, sample_valid, pix_ready,
    input  step_en, pix_addr, pix_data, pix_we
  );
endinterface

// File: rtl/lorenz_plotter.sv
// Projects 7.20 Lorenz solver samples onto a 2-D framebuffer: a blanking
// sweep after reset/clear, then one pixel write per decimated sample.
module lorenz_plotter #(
  parameter int         H_RES    = 640,
  parameter int         V_RES    = 480,
  parameter int         SCALE_SH = 2,
  parameter int         DECIM    = 1,
  parameter logic [7:0] COLOR    = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  lorenz_plotter_if.master   bus,
  input  logic [1:0]         view_sel_i,
  input  logic               clear_req_i,
  output logic               busy_o,
  output logic [31:0]        plot_count_o
);

  localparam int          SHIFT     = 20 - SCALE_SH;
  localparam int          DW        = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

  localparam logic [1:0] ST_CLEAR   = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PROJECT = 2'd2;
  localparam logic [1:0] ST_WRITE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [18:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               we_q, we_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [DW-1:0]      dec_q, dec_d;
  logic               pend_q, pend_d;
  logic signed [26:0] a_q, a_d;
  logic signed [26:0] b_q, b_d;

  logic signed [26:0] sel_a, sel_b;
  logic signed [11:0] sa, sb;
  logic signed [15:0] sx, sy;
  logic [18:0]        proj_addr;
  logic               in_range;
  logic               pend_now;
  logic               go_clear;

  always_comb begin
    case (view_sel_i)
      2'd1:    begin sel_a = bus.x_in; sel_b = bus.z_in; end
      2'd2:    begin sel_a = bus.y_in; sel_b = bus.z_in; end
      default: begin sel_a = bus.x_in; sel_b = bus.y_in; end
    endcase
  end

  // Screen origin at the centre; the vertical axis grows downwards.
  assign sa        = 12'(a_q >>> SHIFT);
  assign sb        = 12'(b_q >>> SHIFT);
  assign sx        = 16'(H_RES / 2) + 16'(sa);
  assign sy        = 16'(V_RES / 2) - 16'(sb);
  assign in_range  = (sx >= 16'sd0) && (sx < 16'(H_RES)) &&
                     (sy >= 16'sd0) && (sy < 16'(V_RES));
  assign proj_addr = 19'(sy * H_RES + sx);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    step_d   = step_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    pend_d   = pend_q;
    a_d      = a_q;
    b_d      = b_q;
    go_clear = 1'b0;
    pend_now = pend_q | clear_req_i;

    case (state_q)
      ST_CLEAR: begin
        if (!we_q) begin
          we_d = 1'b1;
        end else if (bus.pix_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_RUN;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            step_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            addr_d = addr_q + 19'd1;
          end
        end
      end

      ST_RUN: begin
        if (clear_req_i) begin
          go_clear = 1'b1;
        end else if (bus.sample_valid && step_q) begin
          if (dec_q == DEC_LAST) begin
            a_d     = sel_a;
            b_d     = sel_b;
            dec_d   = '0;
            step_d  = 1'b0;
            state_d = ST_PROJECT;
          end else begin
            dec_d = dec_q + 1'b1;
          end
        end
      end

      ST_PROJECT: begin
        if (in_range) begin
          state_d = ST_WRITE;
          addr_d  = proj_addr;
          data_d  = COLOR;
          we_d    = 1'b1;
          pend_d  = pend_now;
        end else if (pend_now) begin
          go_clear = 1'b1;
        end else begin
          state_d = ST_RUN;
          step_d  = 1'b1;
        end
      end

      default: begin
        if (bus.pix_ready) begin
          cnt_d = cnt_q + 32'd1;
          we_d  = 1'b0;
          if (pend_now) begin
            go_clear = 1'b1;
          end else begin
            state_d = ST_RUN;
            step_d  = 1'b1;
          end
        end else begin
          pend_d = pend_now;
        end
      end
    endcase

    // Any path into the sweep restarts it from address 0 with the request idle;
    // plot_count is zeroed only when the sweep completes.
    if (go_clear) begin
      state_d = ST_CLEAR;
      addr_d  = '0;
      data_d  = '0;
      we_d    = 1'b0;
      busy_d  = 1'b1;
      step_d  = 1'b0;
      dec_d   = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      dec_q   <= '0;
      pend_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.step_en  = step_q;
  assign bus.pix_addr = addr_q;
  assign bus.pix_data = data_q;
  assign bus.pix_we   = we_q;
  assign busy_o       = busy_q;
  assign plot_count_o = cnt_q;

endmodule

// File: tb/tb_lorenz_plotter.sv
// Self-checking bench for lorenz_plotter on a reduced 64x48 screen, with a
// second instance (DECIM=4) exercising sample decimation.
module tb_lorenz_plotter;
  localparam int H  = 64;
  localparam int V  = 48;
  localparam int SH = 2;
  localparam int N  = H * V;
  localparam int U  = 1 << 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  vs1, vs4;
  logic        clr1, clr4;
  logic        busy1, busy4;
  logic [31:0] pc1, pc4;

  lorenz_plotter_if bus1 ();
  lorenz_plotter_if bus4 ();

  lorenz_plotter #(.H_RES(H), .V_RES(V), .SCALE_SH(SH), .DECIM(1), .COLOR(8'hFF)) dut (
    .clk(clk), .reset(reset), .bus(bus1), .view_sel_i(vs1), .clear_req_i(clr1),
    .busy_o(busy1), .plot_count_o(pc1));

  lorenz_plotter #(.H_RES(H), .V_RES(V), .SCALE_SH(SH), .DECIM(4), .COLOR(8'hA5)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .view_sel_i(vs4), .clear_req_i(clr4),
    .busy_o(busy4), .plot_count_o(pc4));

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int wr4[$];
  int exp4[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference projection: floor division by the pixel pitch, centred origin.
  function automatic int floor_div(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic bit predict(input int a, input int b, output int addr);
    int px, py;
    px   = H / 2 + floor_div(a, U / (1 << SH));
    py   = V / 2 - floor_div(b, U / (1 << SH));
    addr = py * H + px;
    return (px >= 0) && (px < H) && (py >= 0) && (py < V);
  endfunction

  always @(negedge clk)
    if (!reset && !busy4 && bus4.pix_we && bus4.pix_ready)
      wr4.push_back(int'({bus4.pix_data, bus4.pix_addr}));

  task automatic sweep(input bit rand_ready, input int clr_at);
    int wr, last_a, bad, cyc;
    bit done, tmo;
    wr = 0; last_a = -1; bad = 0; cyc = 0; done = 0; tmo = 0;
    while (!done) begin
      clr1 = 1'b0;
      if (!busy1) done = 1;
      else if (cyc >= 4 * N + 50) begin done = 1; tmo = 1; end
      else begin
        clr1 = (cyc == clr_at);
        bus1.pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (bus1.pix_we && bus1.pix_ready) begin
          if (bus1.pix_addr != 19'(wr) || bus1.pix_data != 8'h00) bad++;
          last_a = int'(bus1.pix_addr);
          wr++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    clr1 = 1'b0;
    chk("sweep_timeout", 32'(tmo), 0);
    chk("sweep_writes", wr, N);
    chk("sweep_last_addr", last_a, N - 1);
    chk("sweep_sequence", bad, 0);
    chk("sweep_step_en", bus1.step_en, 1);
    chk("sweep_we_low", bus1.pix_we, 0);
    chk("sweep_count", pc1, 0);
    exp_cnt = 0;
  endtask

  task automatic send_point(input int xv, input int yv, input int zv, input logic [1:0] vs,
                            input int hold, input bit clr_in_write, input bit junk);
    int a, b, ea, w;
    bit ok;
    w = 0;
    while (!bus1.step_en && w < 50) begin @(negedge clk); w++; end
    chk("pt_step_en_ready", bus1.step_en, 1);
    case (vs)
      2'd1:    begin a = xv; b = zv; end
      2'd2:    begin a = yv; b = zv; end
      default: begin a = xv; b = yv; end
    endcase
    ok = predict(a, b, ea);
    bus1.x_in = 27'(xv); bus1.y_in = 27'(yv); bus1.z_in = 27'(zv);
    vs1 = vs;
    bus1.sample_valid = 1'b1;
    bus1.pix_ready = (hold == 0);
    @(negedge clk);
    vs1 = 2'($urandom_range(0, 3));
    if (junk) begin
      bus1.x_in = 27'($urandom); bus1.y_in = 27'($urandom); bus1.z_in = 27'($urandom);
    end else begin
      bus1.sample_valid = 1'b0;
    end
    chk("capture_step_en", bus1.step_en, 0);
    chk("capture_we", bus1.pix_we, 0);
    @(negedge clk);
    if (!ok) begin
      chk("drop_we", bus1.pix_we, 0);
      chk("drop_step_en", bus1.step_en, 1);
      chk("drop_count", pc1, exp_cnt);
    end else begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_we", bus1.pix_we, 1);
        chk("hold_addr", bus1.pix_addr, ea);
        chk("hold_data", bus1.pix_data, 8'hFF);
        chk("hold_step_en", bus1.step_en, 0);
        clr1 = clr_in_write && (i == 0);
        @(negedge clk);
      end
      clr1 = 1'b0;
      chk("write_we", bus1.pix_we, 1);
      chk("write_addr", bus1.pix_addr, ea);
      chk("write_data", bus1.pix_data, 8'hFF);
      bus1.pix_ready = 1'b1;
      @(negedge clk);
      exp_cnt++;
      chk("write_count", pc1, exp_cnt);
      chk("write_we_done", bus1.pix_we, 0);
      chk("write_step_en", bus1.step_en, clr_in_write ? 0 : 1);
      chk("write_busy", busy1, clr_in_write ? 1 : 0);
    end
    bus1.sample_valid = 1'b0;
  endtask

  task automatic feed4(input int n, inout int m);
    int pres, cyc, ea;
    pres = 0; cyc = 0;
    while (pres < n && cyc < 200) begin
      if (bus4.step_en) begin
        pres++; m++;
        bus4.x_in = 27'(m * (U / 2));
        bus4.sample_valid = 1'b1;
        if (m % 4 == 0 && predict(m * (U / 2), 0, ea))
          exp4.push_back(int'({8'hA5, 19'(ea)}));
      end else begin
        bus4.sample_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus4.sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("dec_feed_done", pres, n);
  endtask

  task automatic cmp4();
    chk("dec_n_writes", wr4.size(), exp4.size());
    for (int i = 0; i < exp4.size() && i < wr4.size(); i++)
      chk("dec_write", wr4[i], exp4[i]);
    wr4.delete();
    exp4.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int m4, cyc, xv, yv, zv;
    reset = 1'b1;
    vs1 = 2'd0; vs4 = 2'd0; clr1 = 1'b0; clr4 = 1'b0;
    bus1.x_in = '0; bus1.y_in = '0; bus1.z_in = '0; bus1.sample_valid = 1'b0; bus1.pix_ready = 1'b1;
    bus4.x_in = '0; bus4.y_in = '0; bus4.z_in = '0; bus4.sample_valid = 1'b0; bus4.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", bus1.pix_we, 0);
    chk("rst_addr", bus1.pix_addr, 0);
    chk("rst_data", bus1.pix_data, 0);
    chk("rst_step_en", bus1.step_en, 0);
    chk("rst_busy", busy1, 1);
    chk("rst_count", pc1, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("we_after_reset", bus1.pix_we, 1);
    chk("addr_after_reset", bus1.pix_addr, 0);
    sweep(1'b0, -1);

    send_point(U, -U, 0, 2'd0, 0, 0, 0);
    send_point(0, 63 * U, 0, 2'd0, 0, 0, 0);
    send_point(3 * U, 2 * U, 0, 2'd0, 3, 0, 0);
    send_point(-8 * U, 0, 0, 2'd0, 0, 0, 0);
    send_point(31 * (U / 4), 0, 0, 2'd0, 0, 0, 1);
    send_point(8 * U, 0, 0, 2'd0, 0, 0, 1);
    send_point(0, 6 * U, 0, 2'd0, 1, 0, 0);
    send_point(0, -23 * (U / 4), 0, 2'd0, 0, 0, 0);
    send_point(0, -6 * U, 0, 2'd0, 0, 0, 0);
    send_point(-1, 0, 0, 2'd0, 0, 0, 0);
    send_point(2 * U, -7 * U, 5 * U, 2'd1, 0, 0, 0);
    send_point(-7 * U, 3 * U, -2 * U, 2'd2, 0, 0, 0);
    send_point(4 * U, -3 * U, 9 * U, 2'd3, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      xv = int'($urandom_range(0, 24 * U)) - 12 * U;
      yv = int'($urandom_range(0, 24 * U)) - 12 * U;
      zv = int'($urandom_range(0, 24 * U)) - 12 * U;
      send_point(xv, yv, zv, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0,
                 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("clr_run_busy", busy1, 1);
    chk("clr_run_step_en", bus1.step_en, 0);
    sweep(1'b1, 50);

    send_point(U, 2 * U, 0, 2'd0, 2, 1, 0);
    sweep(1'b1, 300);
    send_point(-2 * U, -U, 0, 2'd0, 0, 0, 0);

    cyc = 0;
    while (busy4 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("dec_busy", busy4, 0);
    chk("dec_step_en", bus4.step_en, 1);
    wr4.delete();
    m4 = 0;
    feed4(8, m4);
    cmp4();
    chk("dec_count", pc4, 2);
    feed4(2, m4);
    cmp4();
    clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    chk("dec_clr_busy", busy4, 1);
    cyc = 0;
    while (busy4 && cyc < 2 * N + 20) begin @(negedge clk); cyc++; end
    chk("dec_clr_done", busy4, 0);
    chk("dec_clr_count", pc4, 0);
    wr4.delete();
    m4 = 0;
    feed4(4, m4);
    cmp4();
    chk("dec_count_after", pc4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lorenz_plotter.md
LORENZ_PLOTTER -- requirements
Module: lorenz_plotter

Interface
REQ-001 Parameter H_RES, 640, screen width in pixels.
REQ-002 Parameter V_RES, 480, screen height in pixels.
REQ-003 Parameter SCALE_SH, 2, pixels per state unit = 2^SCALE_SH.
REQ-004 Parameter DECIM, 1, plot one of every DECIM accepted samples (DECIM >= 1).
REQ-005 Parameter COLOR, 8'hFF, pixel value written for a plotted point.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 x_in, y_in, z_in  in  27 each  signed 7.20 solver state.
REQ-009 sample_valid  in  1  solver presents a new sample this cycle.
REQ-010 step_en  out  1  solver clock-enable; solver may advance only while high.
REQ-011 view_sel  in  2  projection: 0 = x-y, 1 = x-z, 2 = y-z, 3 = treated as 0.
REQ-012 clear_req  in  1  single-cycle request to blank the framebuffer.
REQ-013 pix_addr  out  19  framebuffer word address = sy*H_RES + sx.
REQ-014 pix_data  out  8  pixel value.
REQ-015 pix_we  out  1  write request; held with addr/data until pix_ready.
REQ-016 pix_ready  in  1  write accepted on any edge where pix_we & pix_ready.
REQ-017 busy  out  1  high while clearing.
REQ-018 plot_count  out  32  number of points written since last reset or clear.

Function
REQ-019 States: CLEAR, RUN, PROJECT, WRITE; all outputs registered.
REQ-020 CLEAR: pix_data=0, pix_we=1, pix_addr steps 0..H_RES*V_RES-1, advancing only on accepted write; after last accepted write -> RUN, busy=0, plot_count=0.
REQ-021 RUN: step_en=1, pix_we=0; each sample_valid increments decimation counter; when counter==DECIM-1 latch view-selected pair (a,b), reset counter, step_en=0 next cycle, -> PROJECT.
REQ-022 sample_valid while step_en=0 SHALL be ignored.
REQ-023 PROJECT (1 cycle): sa = a >>> (20-SCALE_SH), sb = b >>> (20-SCALE_SH), arithmetic shifts, 12-bit signed; sx = H_RES/2 + sa; sy = V_RES/2 - sb.
REQ-024 If 0 <= sx < H_RES and 0 <= sy < V_RES -> WRITE with pix_addr = sy*H_RES+sx, pix_data = COLOR; else drop point -> RUN, no write, plot_count unchanged.
REQ-025 WRITE: pix_we=1, addr/data stable until accepted; on acceptance plot_count += 1 (wraps at 2^32), -> RUN.
REQ-026 Sample-to-write latency: pix_we high 2 cycles after the capturing edge with pix_ready=1; step_en back to 1 the cycle after acceptance.
REQ-027 clear_req in RUN: -> CLEAR next cycle, busy=1, step_en=0, decimation counter cleared.
REQ-028 clear_req in PROJECT or WRITE: set pending flag; current point completes (or drops) normally, then -> CLEAR instead of RUN.
REQ-029 clear_req in CLEAR: ignored; sweep does not restart.
REQ-030 view_sel sampled only at capture; changes elsewhere have no effect on an in-flight point.

Reset
REQ-031 On reset: state CLEAR, pix_addr=0, pix_data=0, pix_we=0, step_en=0, busy=1, plot_count=0, decimation counter=0, pending flag=0.
REQ-032 pix_we SHALL rise the first cycle after reset deasserts; reset mid-WRITE or mid-CLEAR abandons the operation immediately.

Verification
REQ-033 Reset, pix_ready=1 -> exactly 307200 writes of 0, last addr 307199, then busy=0, step_en=1.
REQ-034 view_sel=0, x=+1.0 (27'h0100000), y=-1.0 -> sx=324, sy=244, one write addr 156484 data 8'hFF, plot_count=1.
REQ-035 x=0, y=+63.0 -> sy=-12, no pix_we, plot_count unchanged, step_en=1 two cycles after capture.
REQ-036 Valid point with pix_ready low 3 cycles -> pix_we/addr/data stable, step_en=0 throughout, single write on 4th cycle.
REQ-037 DECIM=4, 8 consecutive valid samples -> only samples 4 and 8 written.
REQ-038 clear_req during WRITE -> point written, plot_count reset to 0 after sweep, busy high for full 307200-write sweep.
